// File: rtl/mem_space_ctrl.sv
// rtl/mem_space_ctrl.sv - sequential MSP430-style memory-space controller with RAM, ROM port and peripheral bridge
module mem_space_ctrl #(
    parameter int AW        = 16,
    parameter int UB_SFR    = 'h0010,
    parameter int UB_PERI8  = 'h0100,
    parameter int UB_PERI16 = 'h0200,
    parameter int UB_RAM    = 'h0400,
    parameter int UB_UNUSED = 'hC000,
    parameter int RAM_WS    = 0,
    parameter int PERI_TO   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [AW-1:0] MAB_in,
    input  logic [15:0]   MDB_in,
    input  logic          MW,
    input  logic          BW,
    output logic [15:0]   MDB_out,
    output logic          rdy,
    output logic          fault,
    output logic          busy,
    output logic [AW-2:0] rom_addr,
    input  logic [15:0]   rom_data,
    output logic [AW-1:0] peri_addr,
    output logic [15:0]   peri_wdata,
    output logic          peri_we,
    output logic          peri_bw,
    output logic          peri_req,
    input  logic          peri_ack,
    input  logic [15:0]   peri_rdata
);

    localparam int RAM_WORDS = (UB_RAM - UB_PERI16) / 2;
    localparam int RAM_IW    = $clog2(RAM_WORDS);

    typedef enum logic [2:0] {IDLE, RAM_WAIT, ROM_RD, PERI_REQ, DONE} state_t;
    typedef enum logic [2:0] {R_SFR, R_PERI8, R_PERI16, R_RAM, R_UNUSED, R_ROM} region_t;

    function automatic region_t decode(input logic [AW-1:0] a);
        if (a < AW'(UB_SFR))         return R_SFR;
        else if (a < AW'(UB_PERI8))  return R_PERI8;
        else if (a < AW'(UB_PERI16)) return R_PERI16;
        else if (a < AW'(UB_RAM))    return R_RAM;
        else if (a < AW'(UB_UNUSED)) return R_UNUSED;
        else                         return R_ROM;
    endfunction

    function automatic logic [15:0] lane_sel(input logic [15:0] w, input logic bw, input logic a0);
        if (!bw)
            return w;
        return a0 ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
    endfunction

    state_t              state, state_nxt;
    region_t             region_in;
    logic                accept;
    logic                is_peri;
    logic [15:0]         cnt;
    logic [15:0]         rd_q;
    logic                flt_q;
    logic                ram_go;
    logic                peri_to;
    logic [15:0]         ram_mem [RAM_WORDS];
    logic [RAM_IW-1:0]   ram_idx;
    logic [15:0]         ram_rdata;

    assign region_in = decode(MAB_in);
    assign is_peri   = (region_in == R_SFR) || (region_in == R_PERI8) || (region_in == R_PERI16);
    // The rdy cycle still counts as busy, so a new request is only taken once it has passed.
    assign accept    = (state == IDLE) && req && !rdy;
    assign busy      = (state != IDLE) || rdy;
    assign ram_go    = (state == RAM_WAIT) && (cnt == 16'(RAM_WS));
    assign peri_to   = (cnt == 16'(PERI_TO - 1));
    assign ram_idx   = RAM_IW'((peri_addr - AW'(UB_PERI16)) >> 1);
    assign ram_rdata = ram_mem[ram_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (region_in)
                        R_SFR, R_PERI8, R_PERI16: state_nxt = PERI_REQ;
                        R_RAM:                    state_nxt = RAM_WAIT;
                        R_ROM:                    state_nxt = MW ? DONE : ROM_RD;
                        default:                  state_nxt = DONE;
                    endcase
                end
            end
            RAM_WAIT: if (ram_go) state_nxt = DONE;
            ROM_RD:   state_nxt = DONE;
            PERI_REQ: if (peri_ack || peri_to) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MDB_out    <= '0;
            rdy        <= 1'b0;
            fault      <= 1'b0;
            rom_addr   <= '0;
            peri_addr  <= '0;
            peri_wdata <= '0;
            peri_we    <= 1'b0;
            peri_bw    <= 1'b0;
            peri_req   <= 1'b0;
            cnt        <= '0;
            rd_q       <= '0;
            flt_q      <= 1'b0;
        end else begin
            rdy   <= 1'b0;
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        peri_addr  <= MAB_in;
                        peri_wdata <= MDB_in;
                        peri_we    <= MW;
                        peri_bw    <= BW || (region_in == R_SFR) || (region_in == R_PERI8);
                        peri_req   <= is_peri;
                        cnt        <= '0;
                        rd_q       <= '0;
                        flt_q      <= (region_in == R_UNUSED) || ((region_in == R_ROM) && MW);
                        if ((region_in == R_ROM) && !MW)
                            rom_addr <= (AW-1)'((MAB_in - AW'(UB_UNUSED)) >> 1);
                    end
                end
                RAM_WAIT: begin
                    if (ram_go) begin
                        if (!peri_we)
                            rd_q <= lane_sel(ram_rdata, peri_bw, peri_addr[0]);
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ROM_RD: rd_q <= lane_sel(rom_data, peri_bw, peri_addr[0]);
                PERI_REQ: begin
                    // Ack wins over a timeout landing in the same cycle.
                    if (peri_ack) begin
                        peri_req <= 1'b0;
                        if (!peri_we)
                            rd_q <= lane_sel(peri_rdata, peri_bw, peri_addr[0]);
                    end else if (peri_to) begin
                        peri_req <= 1'b0;
                        flt_q    <= 1'b1;
                        rd_q     <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: begin
                    rdy   <= 1'b1;
                    fault <= flt_q;
                    if (!peri_we)
                        MDB_out <= rd_q;
                end
                default: ;
            endcase
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_go && peri_we) begin
            if (!peri_bw)
                ram_mem[ram_idx] <= peri_wdata;
            else if (peri_addr[0])
                ram_mem[ram_idx][15:8] <= peri_wdata[7:0];
            else
                ram_mem[ram_idx][7:0] <= peri_wdata[7:0];
        end
    end

endmodule

// File: tb/tb_mem_space_ctrl.sv
// tb/tb_mem_space_ctrl.sv - self-checking bench for mem_space_ctrl
module tb_mem_space_ctrl;

    localparam int PERI_TO = 16;
    localparam int RAM_WS  = 0;

    logic        clk = 1'b0;
    logic        rst_n, req, req3, MW, BW, peri_ack;
    logic [15:0] MAB_in, MDB_in, peri_rdata;
    logic [15:0] MDB_out, rom_data, peri_addr, peri_wdata;
    logic        rdy, fault, busy, peri_we, peri_bw, peri_req;
    logic [14:0] rom_addr;
    logic [15:0] MDB_out3, peri_addr3, peri_wdata3;
    logic        rdy3, fault3, busy3, peri_we3, peri_bw3, peri_req3;
    logic [14:0] rom_addr3;

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [14:0] a);
        return {a, 1'b0} ^ 16'h5AC3;
    endfunction

    assign rom_data = rom_word(rom_addr);

    mem_space_ctrl #(.RAM_WS(RAM_WS), .PERI_TO(PERI_TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .MAB_in(MAB_in), .MDB_in(MDB_in),
        .MW(MW), .BW(BW), .MDB_out(MDB_out), .rdy(rdy), .fault(fault), .busy(busy),
        .rom_addr(rom_addr), .rom_data(rom_data), .peri_addr(peri_addr),
        .peri_wdata(peri_wdata), .peri_we(peri_we), .peri_bw(peri_bw),
        .peri_req(peri_req), .peri_ack(peri_ack), .peri_rdata(peri_rdata)
    );

    mem_space_ctrl #(.RAM_WS(3), .PERI_TO(PERI_TO)) dut_ws3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .MAB_in(MAB_in), .MDB_in(MDB_in),
        .MW(MW), .BW(BW), .MDB_out(MDB_out3), .rdy(rdy3), .fault(fault3), .busy(busy3),
        .rom_addr(rom_addr3), .rom_data(16'h0000), .peri_addr(peri_addr3),
        .peri_wdata(peri_wdata3), .peri_we(peri_we3), .peri_bw(peri_bw3),
        .peri_req(peri_req3), .peri_ack(1'b0), .peri_rdata(16'h0000)
    );

    int          tests = 0;
    int          failed = 0;
    logic [7:0]  model_ram [512];
    logic [15:0] model_mdb;
    logic        s_bw, s_we;
    logic [15:0] s_addr, s_wdata;
    int          s_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int region_of(input logic [15:0] a);
        if (a < 16'h0010) return 0;
        if (a < 16'h0100) return 1;
        if (a < 16'h0200) return 2;
        if (a < 16'h0400) return 3;
        if (a < 16'hC000) return 4;
        return 5;
    endfunction

    function automatic logic [15:0] pick(input logic [15:0] w, input bit bw, input bit odd);
        if (!bw) return w;
        return (w >> (odd ? 8 : 0)) & 16'h00FF;
    endfunction

    // Reference: latency, fault and read data derived from the address map rules.
    task automatic predict(input logic [15:0] a, input logic [15:0] wd, input bit mw, input bit bw,
                           input int ack_dly, input logic [15:0] prd, output int elat, output bit eflt);
        int r;
        int off;
        r = region_of(a);
        eflt = 1'b0;
        elat = 0;
        case (r)
            0, 1, 2: begin
                if (ack_dly < PERI_TO) begin
                    elat = ack_dly + 2;
                    if (!mw) model_mdb = pick(prd, bw || (r < 2), a[0]);
                end else begin
                    elat = PERI_TO + 1;
                    eflt = 1'b1;
                    if (!mw) model_mdb = 16'h0000;
                end
            end
            3: begin
                elat = 2 + RAM_WS;
                off = int'(a) - 'h200;
                if (mw) begin
                    if (bw) model_ram[off] = wd[7:0];
                    else begin
                        model_ram[off & ~1] = wd[7:0];
                        model_ram[off | 1]  = wd[15:8];
                    end
                end else begin
                    model_mdb = pick({model_ram[off | 1], model_ram[off & ~1]}, bw, a[0]);
                end
            end
            4: begin
                elat = 1;
                eflt = 1'b1;
                if (!mw) model_mdb = 16'h0000;
            end
            default: begin
                if (mw) begin
                    elat = 1;
                    eflt = 1'b1;
                end else begin
                    elat = 2;
                    model_mdb = pick(rom_word(15'((int'(a) - 'hC000) / 2)), bw, a[0]);
                end
            end
        endcase
    endtask

    task automatic access(input logic [15:0] a, input logic [15:0] wd, input bit mw, input bit bw,
                          input int ack_dly, input logic [15:0] prd, output int lat, output bit flt);
        int pc;
        @(posedge clk); #1;
        MAB_in = a; MDB_in = wd; MW = mw; BW = bw; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        s_bw = peri_bw; s_we = peri_we; s_addr = peri_addr; s_wdata = peri_wdata;
        lat = 0;
        pc = 0;
        while (!rdy && lat < 100) begin
            if (peri_req) begin
                if (pc == ack_dly) begin
                    peri_ack = 1'b1;
                    peri_rdata = prd;
                end
                pc++;
            end
            @(posedge clk); #1;
            peri_ack = 1'b0;
            lat++;
        end
        s_pc = pc;
        flt = fault;
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] wd, input bit mw, input bit bw,
                       input int ack_dly, input logic [15:0] prd, input string tag);
        int lat, elat;
        bit flt, eflt;
        access(a, wd, mw, bw, ack_dly, prd, lat, flt);
        predict(a, wd, mw, bw, ack_dly, prd, elat, eflt);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_fault"}, flt, eflt);
        check({tag, "_mdb"}, MDB_out, model_mdb);
    endtask

    task automatic acc3(input logic [15:0] a, output int lat);
        @(posedge clk); #1;
        MAB_in = a; MW = 1'b0; BW = 1'b0; req3 = 1'b1;
        @(posedge clk); #1;
        req3 = 1'b0;
        lat = 0;
        while (!rdy3 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, elat, r;
        bit flt, eflt, seen_rdy;
        logic [15:0] a, wd;
        int lo [6] = '{'h0, 'h10, 'h100, 'h200, 'h400, 'hC000};
        int hi [6] = '{'h10, 'h100, 'h200, 'h400, 'hC000, 'h10000};

        rst_n = 1'b0; req = 1'b0; req3 = 1'b0; MW = 1'b0; BW = 1'b0;
        MAB_in = '0; MDB_in = '0; peri_ack = 1'b0; peri_rdata = '0;
        model_mdb = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", {rdy, fault, busy, peri_req, peri_we, peri_bw}, 0);
        check("reset_bus", {MDB_out, peri_addr}, 0);
        check("reset_wd_rom", {peri_wdata, 1'b0, rom_addr}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) begin
            wd = 16'($urandom);
            access(16'('h200 + 2 * i), wd, 1'b1, 1'b0, 0, 16'h0, lat, flt);
            predict(16'('h200 + 2 * i), wd, 1'b1, 1'b0, 0, 16'h0, elat, eflt);
        end

        run(16'h0200, 16'hBEEF, 1'b1, 1'b0, 0, 16'h0, "w0200");
        run(16'h0200, 16'h0000, 1'b0, 1'b0, 0, 16'h0, "r0200");
        check("r0200_beef", MDB_out, 16'hBEEF);
        run(16'h0201, 16'h0012, 1'b1, 1'b1, 0, 16'h0, "bw0201");
        run(16'h0201, 16'h0000, 1'b0, 1'b1, 0, 16'h0, "br0201");
        check("br0201_val", MDB_out, 16'h0012);
        run(16'h0200, 16'h0000, 1'b0, 1'b0, 0, 16'h0, "wr0200");
        check("wr0200_val", MDB_out, 16'h12EF);

        acc3(16'h03FE, lat);
        check("ws3_lat", lat, 5);
        check("ws3_fault", fault3, 0);
        acc3(16'h0400, lat);
        check("ws3_0400_fault", fault3, 1);
        check("ws3_0400_mdb", MDB_out3, 16'h0000);

        run(16'hFFFE, 16'h0000, 1'b0, 1'b0, 0, 16'h0, "rom_fffe");
        check("rom_addr_fffe", rom_addr, 15'h1FFF);
        run(16'hC000, 16'h1234, 1'b1, 1'b0, 0, 16'h0, "rom_write");

        run(16'h0120, 16'h0000, 1'b0, 1'b0, 4, 16'h5A5A, "p0120");
        check("p0120_val", MDB_out, 16'h5A5A);
        run(16'h0020, 16'h00A7, 1'b1, 1'b1, 2, 16'h0, "p0020w");
        check("p0020w_bw", s_bw, 1);
        check("p0020w_cap", {s_we, s_addr, s_wdata}, {1'b1, 16'h0020, 16'h00A7});
        run(16'h0150, 16'h0000, 1'b0, 1'b0, 100, 16'h0, "p_timeout");
        check("p_timeout_req_cycles", s_pc, PERI_TO);
        run(16'h0180, 16'h0000, 1'b0, 1'b0, PERI_TO - 1, 16'hC3C3, "p_ack_at_to");
        run(16'h0005, 16'h0000, 1'b0, 1'b0, 0, 16'hABCD, "sfr_word");
        check("sfr_word_bw", s_bw, 1);

        run(16'h000F, 16'h0000, 1'b0, 1'b0, 1, 16'h7788, "b000f");
        run(16'h0010, 16'h0000, 1'b0, 1'b0, 1, 16'h99AA, "b0010");
        check("b0010_bw", s_bw, 1);
        run(16'h0100, 16'h0000, 1'b0, 1'b0, 1, 16'h1357, "b0100");
        check("b0100_bw", s_bw, 0);
        run(16'h01FF, 16'h0000, 1'b0, 1'b1, 0, 16'h2468, "b01ff");
        run(16'h03FF, 16'h0000, 1'b0, 1'b1, 0, 16'h0, "b03ff");
        run(16'h0400, 16'h0000, 1'b0, 1'b0, 0, 16'h0, "b0400");
        run(16'hBFFF, 16'h0000, 1'b0, 1'b1, 0, 16'h0, "bbfff");
        run(16'hFFFF, 16'h0000, 1'b0, 1'b1, 0, 16'h0, "bffff");

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 5);
            a = 16'(lo[r] + $urandom_range(0, hi[r] - lo[r] - 1));
            run(a, 16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 18),
                16'($urandom), "rand");
        end

        @(posedge clk); #1;
        MAB_in = 16'h0130; MW = 1'b0; BW = 1'b0; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("mid_rst_req_before", peri_req, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_async", {peri_req, busy}, 0);
        model_mdb = 16'h0000;
        seen_rdy = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen_rdy = seen_rdy | rdy;
        end
        check("mid_rst_no_rdy", seen_rdy, 0);
        rst_n = 1'b1;
        run(16'h0200, 16'h0000, 1'b0, 1'b0, 0, 16'h0, "post_rst");
        check("post_rst_val", MDB_out, 16'h12EF);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
